mdio_master: RTL and testbench

Serial MDIO management-frame engine sitting between the PHY configuration sequencer and the external Ethernet PHY pins. It accepts single-register write (and optionally read) commands on the `ctrlData` / `rgAd` / `writeCtrlData` interface that the sequencer drives. It generates MDC and serializes IEEE 802.3 Clause 22 frames on MDIO, and returns read data through a one-cycle valid strobe.

---
 rtl/mdio_master.sv | 105 ++++++++++
 tb/tb_mdio_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO frame engine with MDC generation.
// Define MDIO_READ_EN to include the read path (TA release, data capture, readData strobe).
module mdio_master #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         CLK_DIV  = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ctrlData,
    input  logic [4:0]  rgAd,
    input  logic        writeCtrlData,
    input  logic        readCtrlData,
    output logic        busy,
    output logic [15:0] readData,
    output logic        readDataValid,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} stateT;
    stateT state, stateNext;
    logic [DW-1:0] divCnt;
    logic [5:0]    bitCnt;
    logic [63:0]   frame;
    logic          startRd, start, active, divEnd, rise, bitEnd, rdFrame;
`ifdef MDIO_READ_EN
    logic        isRead;
    logic [15:0] rdShift;
    assign startRd = state == IDLE && readCtrlData && !writeCtrlData;
    assign rdFrame = isRead;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            isRead        <= 1'b0;
            rdShift       <= '0;
            readData      <= '0;
            readDataValid <= 1'b0;
        end else begin
            readDataValid <= 1'b0;
            if (start) isRead <= startRd;
            if (rise && state == DATA && isRead) rdShift <= {rdShift[14:0], mdio_i};
            if (bitEnd && bitCnt == 6'd63 && isRead) begin
                readData      <= rdShift;
                readDataValid <= 1'b1;
            end
        end
    end
`else
    logic unused;
    assign unused        = ^{readCtrlData, mdio_i};
    assign startRd       = 1'b0;
    assign rdFrame       = 1'b0;
    assign readData      = '0;
    assign readDataValid = 1'b0;
`endif
    assign start  = (state == IDLE && writeCtrlData) || startRd;
    assign active = state inside {PRE, HDR, TA, DATA};
    assign divEnd = divCnt == DW'(CLK_DIV - 1);
    assign rise   = active && divEnd && !mdc;
    assign bitEnd = active && divEnd && mdc;
    assign busy   = state != IDLE;
    // frame idles and drains to all ones, so its MSB doubles as the idle-high mdio_o
    assign mdio_o = frame[63];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = start ? PRE : IDLE;
            PRE:     stateNext = (bitEnd && bitCnt == 6'd31) ? HDR : PRE;
            HDR:     stateNext = (bitEnd && bitCnt == 6'd45) ? TA : HDR;
            TA:      stateNext = (bitEnd && bitCnt == 6'd47) ? DATA : TA;
            DATA:    stateNext = (bitEnd && bitCnt == 6'd63) ? DONE : DATA;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame   <= '1;
            mdc     <= 1'b0;
            mdio_oe <= 1'b0;
            divCnt  <= '0;
            bitCnt  <= '0;
        end else if (start) begin
            frame   <= {32'hFFFF_FFFF, 2'b01, startRd ? 2'b10 : 2'b01, PHY_ADDR, rgAd,
                        startRd ? 18'h3FFFF : {2'b10, ctrlData}};
            mdc     <= 1'b0;
            mdio_oe <= 1'b1;
            divCnt  <= '0;
            bitCnt  <= '0;
        end else if (active) begin
            divCnt <= divEnd ? '0 : divCnt + 1'b1;
            if (rise) mdc <= 1'b1;
            if (bitEnd) begin
                mdc     <= 1'b0;
                frame   <= {frame[62:0], 1'b1};
                bitCnt  <= bitCnt == 6'd63 ? bitCnt : bitCnt + 6'd1;
                mdio_oe <= bitCnt != 6'd63 && !(rdFrame && bitCnt >= 6'd45);
            end
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master; frame bits checked at each rising mdc.
// Read-path tests run when MDIO_READ_EN is defined, the read-disabled test otherwise.
`timescale 1ns/1ps
module tb_mdio_master;
    localparam int DIV = 4;
    logic        clk = 1'b0, reset = 1'b0;
    logic [15:0] ctrlData = '0;
    logic [4:0]  rgAd = '0;
    logic        writeCtrlData = 1'b0, readCtrlData = 1'b0;
    logic        busy, readDataValid, mdc, mdio_o, mdio_oe, mdio_i;
    logic [15:0] readData;
    typedef struct packed {logic o; logic oe;} bitT;
    bitT         sb[$];
    int          checks = 0, errors = 0;
    int          bitIdx = 0, validCount = 0, busyCycles = 0, rises = 0;
    logic        prevMdc = 1'b0;
    logic [15:0] phyData = '0;

    always #5 clk = ~clk;

    mdio_master #(.PHY_ADDR(5'd1), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .ctrlData(ctrlData), .rgAd(rgAd),
        .writeCtrlData(writeCtrlData), .readCtrlData(readCtrlData), .busy(busy),
        .readData(readData), .readDataValid(readDataValid), .mdc(mdc),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    // PHY model drives DATA bit i MSB first while DATA bit i is in progress
    assign mdio_i = (bitIdx >= 48 && bitIdx < 64) ? phyData[4'(63 - bitIdx)] : 1'b1;

    always @(negedge clk) begin
        bitT e;
        if (!busy) bitIdx = 0;
        busyCycles += int'(busy);
        validCount += int'(readDataValid);
        if (mdc && !prevMdc) begin
            rises++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit idx=%0d got o=%b oe=%b, no bit expected", bitIdx, mdio_o, mdio_oe);
            end else begin
                e = sb.pop_front();
                if (mdio_oe !== e.oe || (e.oe && mdio_o !== e.o)) begin
                    errors++;
                    $display("FAIL frame_bit idx=%0d got o=%b oe=%b expected o=%b oe=%b", bitIdx, mdio_o, mdio_oe, e.o, e.oe);
                end
            end
            bitIdx++;
        end
        prevMdc = mdc;
    end

    function automatic logic [63:0] mkFrame(input logic rd, input logic [4:0] ad, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, 5'd1, ad, rd ? 18'h3FFFF : {2'b10, d}};
    endfunction

    task automatic pushFrame(input logic rd, input logic [4:0] ad, input logic [15:0] d);
        logic [63:0] f = mkFrame(rd, ad, d);
        for (int i = 0; i < 64; i++) sb.push_back('{o: f[63 - i], oe: !(rd && i >= 46)});
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic w, input logic r, input logic [4:0] ad, input logic [15:0] d);
        rgAd = ad;
        ctrlData = d;
        writeCtrlData = w;
        readCtrlData = r;
        tick();
        writeCtrlData = 1'b0;
        readCtrlData = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout busy=%b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic checkDrained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_bits_left got %0d expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks += 6;
        if (mdc !== 1'b0)           begin errors++; $display("FAIL reset_mdc got %b expected 0", mdc); end
        if (mdio_o !== 1'b1)        begin errors++; $display("FAIL reset_mdio_o got %b expected 1", mdio_o); end
        if (mdio_oe !== 1'b0)       begin errors++; $display("FAIL reset_mdio_oe got %b expected 0", mdio_oe); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (readData !== 16'h0000)  begin errors++; $display("FAIL reset_readData got %h expected 0000", readData); end
        if (readDataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", readDataValid); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write;
        pushFrame(1'b0, 5'd0, 16'h2100);
        busyCycles = 0;
        strobe(1'b1, 1'b0, 5'd0, 16'h2100);
        waitIdle("write");
        checks++;
        if (busyCycles != 128 * DIV + 1) begin
            errors++;
            $display("FAIL write_busy_len got %0d expected %0d", busyCycles, 128 * DIV + 1);
        end
        checkDrained("write");
    endtask

`ifdef MDIO_READ_EN
    task automatic test_read;
        phyData = 16'h796D;
        pushFrame(1'b1, 5'd1, 16'h0000);
        validCount = 0;
        strobe(1'b0, 1'b1, 5'd1, 16'h0000);
        waitIdle("read");
        tick();
        checks += 2;
        if (readData !== 16'h796D) begin errors++; $display("FAIL read_data got %h expected 796d", readData); end
        if (validCount != 1)       begin errors++; $display("FAIL read_valid_count got %0d expected 1", validCount); end
        checkDrained("read");
    endtask
`else
    task automatic test_no_read;
        validCount = 0;
        strobe(1'b0, 1'b1, 5'd2, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (busy !== 1'b0 || mdc !== 1'b0) begin
                errors++;
                $display("FAIL no_read_idle cycle %0d got busy=%b mdc=%b expected 0 0", i, busy, mdc);
            end
            tick();
        end
        checks++;
        if (validCount != 0) begin errors++; $display("FAIL no_read_valid got %0d expected 0", validCount); end
    endtask
`endif

    task automatic test_busy_strobe;
        pushFrame(1'b0, 5'd3, 16'hA5C3);
        rises = 0;
        strobe(1'b1, 1'b0, 5'd3, 16'hA5C3);
        repeat (200) tick();
        strobe(1'b1, 1'b0, 5'd7, 16'h1234);
        waitIdle("busy_strobe");
        repeat (20) tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_strobe_requeued busy=%b expected 0", busy); end
        if (rises != 64)   begin errors++; $display("FAIL busy_strobe_rises got %0d expected 64", rises); end
        checkDrained("busy_strobe");
    endtask

    task automatic test_simultaneous;
        pushFrame(1'b0, 5'd4, 16'h0000);
        validCount = 0;
        strobe(1'b1, 1'b1, 5'd4, 16'h0000);
        waitIdle("simul");
        tick();
        checks++;
        if (validCount != 0) begin errors++; $display("FAIL simul_valid got %0d expected 0", validCount); end
        checkDrained("simul");
    endtask

    task automatic test_back_to_back;
        pushFrame(1'b0, 5'd2, 16'h00FF);
        pushFrame(1'b0, 5'd3, 16'hFF00);
        strobe(1'b1, 1'b0, 5'd2, 16'h00FF);
        waitIdle("b2b_first");
        strobe(1'b1, 1'b0, 5'd3, 16'hFF00);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b expected 1", busy); end
        waitIdle("b2b_second");
        checkDrained("b2b");
    endtask

    task automatic test_reset_mid;
        int n = 0;
        pushFrame(1'b0, 5'd0, 16'hBEEF);
        validCount = 0;
        strobe(1'b1, 1'b0, 5'd0, 16'hBEEF);
        while (bitIdx < 40 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (bitIdx < 40) begin errors++; $display("FAIL reset_mid_reach bit=%0d expected 40", bitIdx); end
        #2 reset = 1'b0;
        #1;
        checks += 6;
        if (mdc !== 1'b0)           begin errors++; $display("FAIL abort_mdc got %b expected 0", mdc); end
        if (mdio_o !== 1'b1)        begin errors++; $display("FAIL abort_mdio_o got %b expected 1", mdio_o); end
        if (mdio_oe !== 1'b0)       begin errors++; $display("FAIL abort_mdio_oe got %b expected 0", mdio_oe); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
        if (readData !== 16'h0000)  begin errors++; $display("FAIL abort_readData got %h expected 0000", readData); end
        if (readDataValid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b expected 0", readDataValid); end
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        pushFrame(1'b0, 5'd1, 16'h0140);
        rises = 0;
        strobe(1'b1, 1'b0, 5'd1, 16'h0140);
        waitIdle("after_reset");
        checks += 2;
        if (rises != 64)     begin errors++; $display("FAIL after_reset_rises got %0d expected 64", rises); end
        if (validCount != 0) begin errors++; $display("FAIL after_reset_valid got %0d expected 0", validCount); end
        checkDrained("after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
`ifdef MDIO_READ_EN
        test_read();
`else
        test_no_read();
`endif
        test_busy_strobe();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
